dmem_line_responder: RTL and testbench
======================================

// Module: dmem_line_responder
// PURPOSE
//  Memory-side responder for the data-cache refill/write-back interface.
//  Accepts one 256-bit line request at a time (read or write) from the cache
//  controller and answers with a single-cycle ack after a fixed latency.
//  Sits between dcache_top's mem_* port and the line-organised backing store.
// PARAMETERS
//  LATENCY      10   cycles from request acceptance to ack; legal range >= 1
//  DEPTH_LINES  512  number of 256-bit lines in the store; power of two
//  LINE_W       256  line width in bits; fixed, must match cache line
// PORTS
//  clk_i        in   1    system clock, all state on rising edge
//  rst_i        in   1    asynchronous, active-low reset
//  mem_enable_i in   1    request valid from cache
//  mem_write_i  in   1    1 = write line, 0 = read line
//  mem_addr_i   in   32   byte address; [4:0] ignored (line aligned)
//  mem_data_i   in   256  write line data
//  mem_ack_o    out  1    one-cycle completion pulse
//  mem_data_o   out  256  read line data, valid in ack cycle
// BEHAVIOUR
//  - Reset (rst_i low, any time, incl. mid-request): state=IDLE, counter=0,
//    mem_ack_o=0, mem_data_o=0, captured request cleared. Array NOT cleared.
//  - States: IDLE, WAIT, ACK (2-bit encoding).
//  - IDLE: on rising edge with mem_enable_i=1, capture addr index, write
//    flag and mem_data_i; go WAIT with counter=LATENCY-1; LATENCY=1 -> ACK.
//  - WAIT: counter decrements each edge; at counter=0 go ACK. Inputs are
//    ignored while in WAIT (captured values are used).
//  - Transition into ACK: write -> array[idx] <= captured data on that edge;
//    read -> mem_data_o <= array[idx] on that edge. mem_ack_o=1 in ACK only.
//  - Ack timing: acceptance at edge E0 -> mem_ack_o high for exactly the
//    cycle following edge E0+LATENCY; never two consecutive ack cycles.
//  - ACK: unconditionally return to IDLE; mem_enable_i ignored in this
//    cycle (cache still holds it high while sampling ack).
//  - Back-to-back: write-back followed by refill (enable held high, write
//    drops after ack) is accepted in the first IDLE cycle after ACK.
//  - mem_data_o holds last read data until next read completes; writes and
//    reset-free idle periods do not disturb it (reset clears it).
//  - Index = mem_addr_i[log2(DEPTH_LINES)+4:5]; upper address bits ignored
//    (aliasing/wrap-around by design, no error signalled).
//  - Read of a line completes after any earlier write to it -> new data.
//  - Counter width = $clog2(LATENCY+1); no overflow possible.
// STRUCTURE
//  - Shared header/package: state encodings, LINE_W=256, line offset=5.
//  - Sub-module dmem_line_array: single-port DEPTH_LINES x LINE_W store,
//    synchronous write, synchronous registered read, enable/write strobes.
//  - Top holds FSM, latency counter, request capture registers, ack.
// TESTING
//  1 Reset: rst_i low -> ack=0, data_o=0; release, no enable -> ack stays 0.
//  2 Write 0xA5..A5 line to addr 0x0000_0040, LATENCY=10 -> ack exactly 10
//    cycles after accept edge, 1 cycle wide; read same addr -> data_o=0xA5..A5.
//  3 Write-back then refill: enable held high, write 1->0 after first ack,
//    addrs 0x400/0x800 -> two acks, read returns line stored at 0x800.
//  4 Alias: write to 0x0000_0020 then read 0x0001_0020 (DEPTH_LINES=512)
//    -> returns same line; mem_addr_i[4:0]=0x1F has no effect.
//  5 Input churn during WAIT (addr/data/write toggled) -> result matches
//    captured request; LATENCY=1 build -> ack one cycle after accept.
//  6 Reset asserted mid-WAIT -> no ack emitted; next request served normally,
//    previously written lines still readable.

Source files
------------

// File: rtl/dmem_line_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_line_responder_pkg
//   Shared definitions for the data-memory line responder.
//   - state_e     : responder FSM encoding (2-bit).
//   - LINE_BITS   : cache line width in bits (fixed at 256).
//   - LINE_OFFSET : number of byte-offset address bits below the line index.
//   - ADDR_W      : byte address width on the cache-facing port.
// -----------------------------------------------------------------------------
package dmem_line_responder_pkg;

    localparam int ADDR_W      = 32;
    localparam int LINE_BITS   = 256;
    localparam int LINE_OFFSET = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

endpackage : dmem_line_responder_pkg

// File: rtl/dmem_line_array.sv
// -----------------------------------------------------------------------------
// dmem_line_array
//   Single-port DEPTH_LINES x LINE_W line store with synchronous write and a
//   synchronous, registered read port. The read register holds its value
//   until the next read strobe.
// Ports
//   clk_i    in  1       clock, rising edge
//   rst_i    in  1       asynchronous active-low reset (read register only)
//   en_i     in  1       access strobe
//   we_i     in  1       1 = write wdata_i, 0 = read into rdata_o
//   idx_i    in  IDX_W   line index
//   wdata_i  in  LINE_W  write line data
//   rdata_o  out LINE_W  registered read data
// -----------------------------------------------------------------------------
module dmem_line_array #(
    parameter int DEPTH_LINES = 512,
    parameter int LINE_W      = 256,
    localparam int IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem [DEPTH_LINES];

    // NOTE: the storage array has no reset; clearing it would turn a plain
    // RAM into a huge flop bank, and contents must survive reset anyway.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_o <= '0;
        end else if (en_i && !we_i) begin
            rdata_o <= mem[idx_i];
        end
    end

endmodule : dmem_line_array

// File: rtl/dmem_line_responder.sv
// -----------------------------------------------------------------------------
// dmem_line_responder
//   Memory-side responder for the data-cache refill/write-back interface.
//   Accepts one line request at a time, waits LATENCY edges and then pulses
//   mem_ack_o for one cycle. Writes land in the store on the edge entering
//   ACK; reads load mem_data_o on that same edge and hold it until the next
//   read completes.
// Ports
//   clk_i        in  1       clock, rising edge
//   rst_i        in  1       asynchronous active-low reset
//   mem_enable_i in  1       request valid
//   mem_write_i  in  1       1 = write line, 0 = read line
//   mem_addr_i   in  32      byte address, [4:0] ignored
//   mem_data_i   in  LINE_W  write line data
//   mem_ack_o    out 1       one-cycle completion pulse
//   mem_data_o   out LINE_W  read line data, valid in ack cycle and held
// -----------------------------------------------------------------------------
module dmem_line_responder
    import dmem_line_responder_pkg::*;
#(
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 512,
    parameter int LINE_W      = LINE_BITS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_ack_o,
    output logic [LINE_W-1:0] mem_data_o
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_line_responder: LATENCY must be >= 1");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               capture;
    logic               array_en;

    logic [IDX_W-1:0]   cap_idx_q;
    logic               cap_we_q;
    logic [LINE_W-1:0]  cap_data_q;

    // Upper address bits alias onto the same lines; byte offset is irrelevant.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[ADDR_W-1:LINE_OFFSET+IDX_W],
                                mem_addr_i[LINE_OFFSET-1:0]};

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        array_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_enable_i) begin
                    capture = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The store access is issued on the edge that enters ACK, so
                // read data is already registered during the ack cycle.
                if (cnt_q == '0) begin
                    array_en = 1'b1;
                    state_d  = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                // Enable is still high here while the cache samples the ack.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cap_idx_q  <= '0;
            cap_we_q   <= 1'b0;
            cap_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                cap_idx_q  <= mem_addr_i[LINE_OFFSET +: IDX_W];
                cap_we_q   <= mem_write_i;
                cap_data_q <= mem_data_i;
            end
        end
    end

    assign mem_ack_o = (state_q == ST_ACK);

    dmem_line_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .LINE_W      (LINE_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (array_en),
        .we_i    (cap_we_q),
        .idx_i   (cap_idx_q),
        .wdata_i (cap_data_q),
        .rdata_o (mem_data_o)
    );

endmodule : dmem_line_responder

// File: tb/tb_dmem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_line_responder
//   Directed bench for dmem_line_responder. dut_a uses LATENCY=10, dut_b uses
//   LATENCY=1; both DEPTH_LINES=512. Outputs are sampled 1 time unit after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_line_responder;

    logic         clk_i;
    logic         rst_i;

    logic         en_a, we_a, ack_a;
    logic [31:0]  addr_a;
    logic [255:0] wd_a, rd_a;

    logic         en_b, we_b, ack_b;
    logic [31:0]  addr_b;
    logic [255:0] wd_b, rd_b;

    int vectors;
    int miscompares;

    localparam logic [255:0] D_A5 = {32{8'hA5}};
    localparam logic [255:0] D1   = {8{32'h0400_BEEF}};
    localparam logic [255:0] D2   = {8{32'h0800_CAFE}};
    localparam logic [255:0] D3   = {8{32'h0020_1234}};
    localparam logic [255:0] D4   = {8{32'h0060_5A5A}};
    localparam logic [255:0] D5   = {8{32'h0080_0F0F}};
    localparam logic [255:0] D6   = {8{32'hDEAD_0040}};

    dmem_line_responder #(.LATENCY(10), .DEPTH_LINES(512), .LINE_W(256)) dut_a (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_enable_i (en_a),
        .mem_write_i  (we_a),
        .mem_addr_i   (addr_a),
        .mem_data_i   (wd_a),
        .mem_ack_o    (ack_a),
        .mem_data_o   (rd_a)
    );

    dmem_line_responder #(.LATENCY(1), .DEPTH_LINES(512), .LINE_W(256)) dut_b (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_enable_i (en_b),
        .mem_write_i  (we_b),
        .mem_addr_i   (addr_b),
        .mem_data_i   (wd_b),
        .mem_ack_o    (ack_b),
        .mem_data_o   (rd_b)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Counts edges until the selected ack is seen (bounded). Optional churn
    // scrambles dut_a's inputs every waiting cycle.
    task automatic wait_ack(input bit sel, input bit churn, output int lat);
        lat = 0;
        while (!(sel ? ack_b : ack_a) && lat < 64) begin
            if (churn) begin
                we_a   = 1'($urandom_range(0, 1));
                addr_a = $urandom;
                wd_a   = {8{$urandom}};
            end
            tick();
            lat++;
        end
    endtask

    // Presents a request, accepts it on the next edge and waits for the ack.
    // Returns in the ack cycle. Unless hold is set, enable drops after the
    // accept edge and the cycle after ack is checked to be ack-free.
    task automatic req(input bit sel, input bit wr, input logic [31:0] addr,
                       input logic [255:0] data, input bit hold, input bit churn,
                       output int lat);
        if (sel) begin
            en_b = 1'b1; we_b = wr; addr_b = addr; wd_b = data;
        end else begin
            en_a = 1'b1; we_a = wr; addr_a = addr; wd_a = data;
        end
        tick();
        if (!hold) begin
            if (sel) en_b = 1'b0;
            else     en_a = 1'b0;
        end
        wait_ack(sel, churn, lat);
        if (!hold) begin
            tick();
            check("ack_one_cycle", 256'(sel ? ack_b : ack_a), 256'(0));
        end
    endtask

    initial begin
        int lat;
        int acks;
        vectors     = 0;
        miscompares = 0;
        en_a = 0; we_a = 0; addr_a = '0; wd_a = '0;
        en_b = 0; we_b = 0; addr_b = '0; wd_b = '0;
        rst_i = 1'b0;

        // 1: reset state, then idle with no enable
        tick(); tick();
        check("rst_ack", 256'(ack_a), 256'(0));
        check("rst_data", rd_a, 256'(0));
        rst_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack_a) acks++;
        end
        check("idle_no_ack", 256'(acks), 256'(0));

        // 2: write A5 line, latency 10, read it back; write leaves data_o alone
        req(0, 1, 32'h0000_0040, D_A5, 0, 0, lat);
        check("wr_latency", 256'(lat), 256'(10));
        check("wr_keeps_data", rd_a, 256'(0));
        req(0, 0, 32'h0000_0040, '0, 0, 0, lat);
        check("rd_latency", 256'(lat), 256'(10));
        check("rd_a5", rd_a, D_A5);

        // 3: write-back then refill with enable held high across the ack
        req(0, 1, 32'h0000_0800, D2, 0, 0, lat);
        req(0, 1, 32'h0000_0400, D1, 1, 0, lat);
        check("wb_latency", 256'(lat), 256'(10));
        we_a = 1'b0; addr_a = 32'h0000_0800;
        tick();
        check("b2b_gap", 256'(ack_a), 256'(0));
        tick();
        en_a = 1'b0;
        wait_ack(0, 0, lat);
        check("refill_latency", 256'(lat), 256'(10));
        check("refill_data", rd_a, D2);
        tick();
        req(0, 0, 32'h0000_0400, '0, 0, 0, lat);
        check("wb_line", rd_a, D1);

        // 4: aliasing of upper address bits and ignored byte offset
        req(0, 1, 32'h0000_0020, D3, 0, 0, lat);
        req(0, 0, 32'h0001_0020, '0, 0, 0, lat);
        check("alias_hi", rd_a, D3);
        req(0, 0, 32'h0000_0800, '0, 0, 0, lat);
        req(0, 0, 32'h0000_003F, '0, 0, 0, lat);
        check("alias_offset", rd_a, D3);

        // 5: input churn during WAIT, then the LATENCY=1 build
        req(0, 1, 32'h0000_0060, D4, 0, 1, lat);
        check("churn_latency", 256'(lat), 256'(10));
        en_a = 0; we_a = 0;
        req(0, 0, 32'h0000_0060, '0, 0, 0, lat);
        check("churn_data", rd_a, D4);
        req(1, 1, 32'h0000_0080, D5, 0, 0, lat);
        check("l1_wr_latency", 256'(lat), 256'(1));
        req(1, 0, 32'h0000_0080, '0, 0, 0, lat);
        check("l1_rd_latency", 256'(lat), 256'(1));
        check("l1_rd_data", rd_b, D5);

        // 6: reset mid-WAIT aborts the write; stored lines survive
        en_a = 1'b1; we_a = 1'b1; addr_a = 32'h0000_0040; wd_a = D6;
        tick();
        en_a = 1'b0;
        tick(); tick(); tick();
        rst_i = 1'b0;
        #1;
        check("midrst_ack", 256'(ack_a), 256'(0));
        check("midrst_data", rd_a, 256'(0));
        tick();
        rst_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ack_a) acks++;
        end
        check("midrst_no_ack", 256'(acks), 256'(0));
        req(0, 0, 32'h0000_0040, '0, 0, 0, lat);
        check("post_rst_latency", 256'(lat), 256'(10));
        check("post_rst_a5", rd_a, D_A5);
        req(0, 0, 32'h0000_0800, '0, 0, 0, lat);
        check("post_rst_d2", rd_a, D2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dmem_line_responder
